// File: rtl/med_filter_frame_seq.sv
// Frame sequencer for the 3x3 median filter: reads one frame from memory, streams it as
// vsync/href/gray with blanking and trailing drain lines, and checks the returned line count.
module med_filter_frame_seq #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int H_BLANK    = 160,
  parameter int V_PRE      = 16,
  parameter int V_TAIL     = 2,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              img_vsync,
  output logic              img_href,
  output logic [7:0]        img_gray,
  input  logic              filt_href,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRE    = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_TAIL   = 3'd4;

  localparam int LINE_LEN = IMG_H_DISP + H_BLANK;
  localparam int TAIL_LEN = V_TAIL * LINE_LEN;
  localparam int CNT_W    = $clog2(TAIL_LEN + V_PRE + IMG_H_DISP + 1);
  localparam int LINE_W   = $clog2(IMG_V_DISP + 1);
  localparam int LCNT_W   = $clog2(IMG_V_DISP + 2);

  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(V_PRE - 1);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(IMG_H_DISP - 1);
  localparam logic [CNT_W-1:0]  HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(TAIL_LEN - 1);
  localparam logic [LINE_W-1:0] V_LAST    = LINE_W'(IMG_V_DISP - 1);
  localparam logic [LCNT_W-1:0] LCNT_EXP  = LCNT_W'(IMG_V_DISP);
  localparam logic [LCNT_W-1:0] LCNT_MAX  = '1;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              href_p1_q, href_p1_d;
  logic              vsync_p1_q, vsync_p1_d;
  logic              img_href_q, img_href_d;
  logic              img_vsync_q, img_vsync_d;
  logic [7:0]        img_gray_q, img_gray_d;
  logic              filt_href_q, filt_href_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic start_acc, abort_acc, href_i, vsync_i, filt_fall, count_en;

  always_comb begin
    start_acc = (state_q == S_IDLE) && start && !abort;
    abort_acc = (state_q != S_IDLE) && abort;
    href_i    = (state_q == S_ACTIVE);
    vsync_i   = (state_q != S_IDLE);
    filt_fall = filt_href_q && !filt_href;
    count_en  = vsync_i || vsync_p1_q || img_vsync_q;
    filt_href_d = filt_href;

    // An edge in the accepting cycle belongs to the new frame.
    lcnt_d = lcnt_q;
    if (start_acc) begin
      lcnt_d = filt_fall ? LCNT_W'(1) : '0;
    end else if (filt_fall && count_en && (lcnt_q != LCNT_MAX)) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end

    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    line_d  = line_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_acc) begin
          state_d = S_PRE;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (cnt_q == H_LAST) begin
          state_d = S_HBLANK;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          if (line_q == V_LAST) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_ACTIVE;
            line_d  = line_q + LINE_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (cnt_q == T_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = (lcnt_d != LCNT_EXP);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort flushes both pipe stages so no partial line leaks out.
    if (abort_acc) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = err_q;
    end

    href_p1_d   = abort_acc ? 1'b0 : href_i;
    vsync_p1_d  = abort_acc ? 1'b0 : vsync_i;
    img_href_d  = abort_acc ? 1'b0 : href_p1_q;
    img_vsync_d = abort_acc ? 1'b0 : vsync_p1_q;
    img_gray_d  = (!abort_acc && href_p1_q) ? mem_rd_data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      href_p1_q   <= 1'b0;
      vsync_p1_q  <= 1'b0;
      img_href_q  <= 1'b0;
      img_vsync_q <= 1'b0;
      img_gray_q  <= 8'h00;
      filt_href_q <= 1'b0;
      lcnt_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      href_p1_q   <= href_p1_d;
      vsync_p1_q  <= vsync_p1_d;
      img_href_q  <= img_href_d;
      img_vsync_q <= img_vsync_d;
      img_gray_q  <= img_gray_d;
      filt_href_q <= filt_href_d;
      lcnt_q      <= lcnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd_en   = (state_q == S_ACTIVE);
  assign mem_rd_addr = addr_q;
  assign img_vsync   = img_vsync_q;
  assign img_href    = img_href_q;
  assign img_gray    = img_gray_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign line_err    = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_med_filter_frame_seq.sv
// Bench for med_filter_frame_seq on a 4x3 frame: closed-form timing model plus a pixel scoreboard.
module tb_med_filter_frame_seq;

  localparam int H = 4, V = 3, HB = 2, VP = 3, VT = 2, AW = 4;
  localparam int LL = H + HB;
  localparam int LAST_BUSY = VP + V * LL + VT * LL;
  localparam int DONE_T = LAST_BUSY + 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, filt_href;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data;
  logic          img_vsync, img_href, busy, frame_done, line_err;
  logic [7:0]    img_gray;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic exp_line_err = 1'b0;

  med_filter_frame_seq #(.IMG_H_DISP(H), .IMG_V_DISP(V), .H_BLANK(HB), .V_PRE(VP),
                         .V_TAIL(VT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .img_vsync(img_vsync), .img_href(img_href), .img_gray(img_gray),
    .filt_href(filt_href), .busy(busy), .frame_done(frame_done),
    .line_err(line_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory returns data = address one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'(mem_rd_addr);
    else           mem_rd_data <= 8'($urandom_range(0, 255));
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_rd(input int t);
    int u;
    if (t < 1 + VP) return 1'b0;
    u = t - 1 - VP;
    return ((u / LL) < V) && ((u % LL) < H);
  endfunction

  function automatic int m_addr(input int t);
    int u;
    u = t - 1 - VP;
    return (u / LL) * H + (u % LL);
  endfunction

  function automatic bit m_busy(input int t);
    return (t >= 1) && (t <= LAST_BUSY);
  endfunction

  task automatic check_gray();
    if (img_href) begin
      if (exp_q.size() > 0) chk("gray", {24'h0, img_gray}, {24'h0, exp_q.pop_front()});
      else                  chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      chk("gray_idle", {24'h0, img_gray}, 32'd0);
    end
  endtask

  // Cycle t=0 is the cycle start is driven; prestarted means that cycle was the previous frame's done cycle.
  task automatic run_frame(input int npulse, input int ign_t, input int abort_t,
                           input bit b2b, input bit prestarted);
    int t_end;
    bit ab, e_rd, e_busy, e_href, e_vs, e_err;
    ab = (abort_t >= 0);
    t_end = b2b ? DONE_T : (ab ? abort_t + 5 : DONE_T + 3);
    e_err = ab ? 1'b0 : (npulse != V);
    for (int i = 0; i < H * V; i++) exp_q.push_back(8'(i));
    for (int t = (prestarted ? 1 : 0); t <= t_end; t++) begin
      start = (t == 0) || (t == ign_t) || (b2b && t == DONE_T);
      abort = (t == abort_t);
      filt_href = (t >= 22) && (t < 22 + 2 * npulse) && (((t - 22) % 2) == 0);
      @(negedge clk);
      e_rd   = (ab && t > abort_t) ? 1'b0 : m_rd(t);
      e_busy = (ab && t > abort_t) ? 1'b0 : m_busy(t);
      chk("rd_en", {31'h0, mem_rd_en}, {31'h0, e_rd});
      chk("busy", {31'h0, busy}, {31'h0, e_busy});
      if (e_rd) chk("addr", {28'h0, mem_rd_addr}, 32'(m_addr(t)));
      chk("frame_done", {31'h0, frame_done}, {31'h0, (!ab && t == DONE_T)});
      if (!(ab && t == abort_t + 1)) begin
        if (ab && t >= abort_t + 2) begin
          e_href = 1'b0;
          e_vs   = 1'b0;
        end else begin
          e_href = (t >= 2) && m_rd(t - 2);
          e_vs   = ((t >= 2) && m_busy(t - 2)) || (prestarted && t == 1);
        end
        chk("img_href", {31'h0, img_href}, {31'h0, e_href});
        chk("img_vsync", {31'h0, img_vsync}, {31'h0, e_vs});
      end
      check_gray();
      if (t == 0)            chk("line_err_prev", {31'h0, line_err}, {31'h0, exp_line_err});
      else if (t < DONE_T)   chk("line_err_run", {31'h0, line_err}, 32'd0);
      else                   chk("line_err_end", {31'h0, line_err}, {31'h0, e_err});
      if (!ab && t == DONE_T) chk("addr_hold", {28'h0, mem_rd_addr}, 32'(H * V - 1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    filt_href = 1'b0;
    exp_line_err = e_err;
    if (ab)        exp_q.delete();
    else if (!b2b) chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int n, input bit st_ab);
    for (int i = 0; i < n; i++) begin
      start = st_ab && (i == 0);
      abort = st_ab && (i == 0);
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'd0);
      chk("idle_rd_en", {31'h0, mem_rd_en}, 32'd0);
      chk("idle_vsync", {31'h0, img_vsync}, 32'd0);
      chk("idle_done", {31'h0, frame_done}, 32'd0);
      chk("idle_line_err", {31'h0, line_err}, {31'h0, exp_line_err});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    filt_href = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outs", {21'h0, mem_rd_en, img_vsync, img_href, img_gray, busy, frame_done, line_err},
          32'd0);
      chk("rst_addr", {28'h0, mem_rd_addr}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    idle_cycles(2, 1'b0);
    run_frame(3, 5, -1, 1'b1, 1'b0);
    run_frame(2, -1, -1, 1'b0, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(3, 1'b1);
    run_frame(0, -1, 11, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    run_frame(3, -1, -1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
